// File: rtl/fp_normalizer_pkg.sv
// Shared definitions for the floating-point post-add normalizer.
// Holds the default field widths, packed-field bit positions for the
// default-width sum/result words, the all-ones exponent, and the FSM
// state encoding.
package fp_normalizer_pkg;

    localparam int FP_E_WIDTH = 8;
    localparam int FP_M_WIDTH = 23;

    // Raw sum word: {sign, exp, mant[M:0]} (mant carries one extra carry bit)
    localparam int SUM_W       = FP_E_WIDTH + FP_M_WIDTH + 2;
    localparam int SUM_SIGN    = SUM_W - 1;
    localparam int SUM_EXP_HI  = SUM_W - 2;
    localparam int SUM_EXP_LO  = FP_M_WIDTH + 1;
    localparam int SUM_MANT_HI = FP_M_WIDTH;

    // Normalized result word: {sign, exp, mant[M-1:0]}
    localparam int RES_W       = FP_E_WIDTH + FP_M_WIDTH + 1;
    localparam int RES_SIGN    = RES_W - 1;
    localparam int RES_EXP_HI  = RES_W - 2;
    localparam int RES_EXP_LO  = FP_M_WIDTH;
    localparam int RES_MANT_HI = FP_M_WIDTH - 1;

    localparam logic [FP_E_WIDTH-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_SHIFT = 2'd2,
        ST_OUT   = 2'd3
    } norm_state_t;

endpackage

// File: rtl/fp_norm_shift_step.sv
// One combinational left-normalization step.
// Ports:
//   exp_cur, mant_cur   current exponent / raw mantissa (carry bit clear)
//   next_exp, next_mant values after at most one left shift
//   done                normalization finished (leading one reached or exp hit 0)
//   unf                 finished without reaching the leading one (denormal)
// The done/unf decision looks at the shifted value so the caller can leave
// its shift loop in the same cycle as the final shift.
module fp_norm_shift_step
    import fp_normalizer_pkg::*;
#(
    parameter int E_WIDTH = FP_E_WIDTH,
    parameter int M_WIDTH = FP_M_WIDTH
) (
    input  logic [E_WIDTH-1:0] exp_cur,
    input  logic [M_WIDTH:0]   mant_cur,
    output logic [E_WIDTH-1:0] next_exp,
    output logic [M_WIDTH:0]   next_mant,
    output logic               done,
    output logic               unf
);

    logic [E_WIDTH-1:0] exp_dec;
    logic [M_WIDTH:0]   mant_shl;

    assign exp_dec  = exp_cur - 1'b1;
    assign mant_shl = {mant_cur[M_WIDTH-1:0], 1'b0};

    always_comb begin
        next_exp  = exp_cur;
        next_mant = mant_cur;
        done      = 1'b1;
        unf       = 1'b0;
        if (exp_cur == '0) begin
            // Exponent exhausted: no further shift possible.
            unf = ~mant_cur[M_WIDTH-1];
        end else if (!mant_cur[M_WIDTH-1]) begin
            next_exp  = exp_dec;
            next_mant = mant_shl;
            done      = mant_shl[M_WIDTH-1] | (exp_dec == '0);
            unf       = ~mant_shl[M_WIDTH-1] & (exp_dec == '0);
        end
    end

endmodule

// File: rtl/fp_normalizer.sv
// Post-add normalization stage. Accepts a raw {sign, exp, mant[M:0]} sum,
// normalizes one shift per cycle, and presents {sign, exp, mant[M-1:0]}
// with zero/overflow/underflow flags. One operation in flight.
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   valid_in/ready_in   upstream handshake (ready_in high only when idle)
//   s_case_in, sum_in   special-case marker and raw sum
//   valid_out/ready_out downstream handshake
//   result              normalized packed result
//   zero_flag, ovf_flag, unf_flag  result status, held with result
//
// state | meaning
// IDLE  | waiting for an operand, ready_in high
// CHECK | classify operand: special / zero / carry / normalized / needs shift
// SHIFT | one left shift per cycle until leading one or exponent reaches 0
// OUT   | result presented, held until ready_out
module fp_normalizer
    import fp_normalizer_pkg::*;
#(
    parameter int E_WIDTH = FP_E_WIDTH,
    parameter int M_WIDTH = FP_M_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    output logic                       ready_in,
    input  logic                       s_case_in,
    input  logic [E_WIDTH+M_WIDTH+1:0] sum_in,
    output logic                       valid_out,
    input  logic                       ready_out,
    output logic [E_WIDTH+M_WIDTH:0]   result,
    output logic                       zero_flag,
    output logic                       ovf_flag,
    output logic                       unf_flag
);

    localparam logic [E_WIDTH-1:0] E_ALL_ONES = '1;
    localparam logic [E_WIDTH-1:0] E_MAX_M1   = E_ALL_ONES - 1'b1;

    norm_state_t state_q, state_d;

    logic                     sign_q, sign_d;
    logic                     scase_q, scase_d;
    logic [E_WIDTH-1:0]       exp_q, exp_d;
    logic [M_WIDTH:0]         mant_q, mant_d;
    logic [E_WIDTH+M_WIDTH:0] result_q, result_d;
    logic                     zero_q, zero_d;
    logic                     ovf_q, ovf_d;
    logic                     unf_q, unf_d;

    logic [E_WIDTH-1:0]       step_exp;
    logic [M_WIDTH:0]         step_mant;
    logic                     step_done;
    logic                     step_unf;

    fp_norm_shift_step #(
        .E_WIDTH (E_WIDTH),
        .M_WIDTH (M_WIDTH)
    ) u_step (
        .exp_cur   (exp_q),
        .mant_cur  (mant_q),
        .next_exp  (step_exp),
        .next_mant (step_mant),
        .done      (step_done),
        .unf       (step_unf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        scase_d  = scase_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    sign_d   = sum_in[E_WIDTH+M_WIDTH+1];
                    exp_d    = sum_in[E_WIDTH+M_WIDTH:M_WIDTH+1];
                    mant_d   = sum_in[M_WIDTH:0];
                    scase_d  = s_case_in;
                    result_d = '0;
                    zero_d   = 1'b0;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_OUT;
                if (scase_q) begin
                    result_d = {sign_q, exp_q, mant_q[M_WIDTH-1:0]};
                end else if (mant_q == '0) begin
                    result_d = '0;
                    zero_d   = 1'b1;
                end else if (mant_q[M_WIDTH]) begin
                    // Carry: shift right (truncating). An incremented exponent
                    // of all ones, or an input already at all ones, saturates
                    // to the overflow encoding rather than wrapping.
                    if (exp_q >= E_MAX_M1) begin
                        result_d = {sign_q, E_ALL_ONES, {M_WIDTH{1'b0}}};
                        ovf_d    = 1'b1;
                    end else begin
                        result_d = {sign_q, exp_q + 1'b1, mant_q[M_WIDTH:1]};
                    end
                end else if (mant_q[M_WIDTH-1]) begin
                    result_d = {sign_q, exp_q, mant_q[M_WIDTH-1:0]};
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                exp_d  = step_exp;
                mant_d = step_mant;
                if (step_done) begin
                    result_d = {sign_q, step_exp, step_mant[M_WIDTH-1:0]};
                    unf_d    = step_unf;
                    state_d  = ST_OUT;
                end
            end
            ST_OUT: begin
                if (ready_out) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_q   <= 1'b0;
            scase_q  <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            sign_q   <= sign_d;
            scase_q  <= scase_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign ready_in  = (state_q == ST_IDLE);
    assign valid_out = (state_q == ST_OUT);
    assign result    = result_q;
    assign zero_flag = zero_q;
    assign ovf_flag  = ovf_q;
    assign unf_flag  = unf_q;

endmodule

// File: doc/fp_normalizer.md
Name: fp_normalizer

Overview:
- Floating-point post-add normalization stage; sits directly downstream of the mantissa add/subtract stage and consumes its registered packed sum.
- Input format: {sign, exp, mant} with an (M_WIDTH+1)-bit raw mantissa. Bit M_WIDTH is the carry position; bit M_WIDTH-1 is the target leading-one position.
- Normalizes iteratively, one shift per cycle, adjusting the exponent as it goes. Returns a packed {sign, exp, mant} result plus zero/overflow/underflow flags.
- Uses valid/ready handshakes on both sides.

Parameters:
- E_WIDTH, 8, exponent field width
- M_WIDTH, 23, mantissa field width; raw input mantissa is M_WIDTH+1 bits

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- valid_in  in  1  upstream sum valid
- ready_in  out  1  block can accept; high only in IDLE
- s_case_in  in  1  special-case (inf/NaN/passthrough) marker accompanying sum_in
- sum_in  in  E_WIDTH+M_WIDTH+2  {sign, exp[E_WIDTH-1:0], mant[M_WIDTH:0]}
- valid_out  out  1  result valid
- ready_out  in  1  downstream accepts result
- result  out  E_WIDTH+M_WIDTH+1  {sign, exp, mant[M_WIDTH-1:0]}
- zero_flag  out  1  result is zero
- ovf_flag  out  1  exponent overflow
- unf_flag  out  1  exponent underflow (denormal result)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; result, all flags and valid_out = 0; ready_in = 1 once released.
- FSM states: IDLE, CHECK, SHIFT, OUT.
- IDLE:
  - On valid_in && ready_in, register sign, exp, mant and s_case_in, then go to CHECK.
  - ready_in = 1 only in IDLE; no input is accepted in any other state.
- CHECK (one cycle), priority order:
  1. s_case set: result = {sign, exp, mant[M_WIDTH-1:0]} unchanged, no flags → OUT.
  2. mant == 0: result = all zeros with sign 0, zero_flag = 1 → OUT.
  3. mant[M_WIDTH] set: mant >>= 1 (LSB truncated, round toward zero), exp += 1.
     - If the new exp is all ones: mant = 0, ovf_flag = 1 → OUT.
     - Otherwise → OUT.
  4. mant[M_WIDTH-1] set: already normalized → OUT.
  5. Otherwise → SHIFT.
- SHIFT (one cycle per shift):
  - If mant[M_WIDTH-1] == 0 and exp != 0: mant <<= 1, exp -= 1.
  - Leave SHIFT for OUT when mant[M_WIDTH-1] == 1.
  - If exp reaches 0 before normalization, stop and set unf_flag = 1; the mantissa stays as shifted.
  - Shift count is bounded by M_WIDTH-1, since mant is non-zero here.
- OUT:
  - valid_out = 1; result and flags are held stable while ready_out = 0.
  - On ready_out = 1, go to IDLE; valid_out drops the next cycle.
  - Flags clear on the next accept.
- Latency, accept edge to valid_out high:
  - 2 cycles when no left shift is needed.
  - 2+N cycles for N left shifts; worst case M_WIDTH+1.
- Throughput: one operation in flight; no overlap of accept and output.
- Reset mid-operation (any state) aborts immediately to reset values; no partial result is ever presented.
- valid_in while busy: ignored, and upstream must hold it per the ready_in handshake.
- Exponent arithmetic is unsigned, E_WIDTH bits. It never wraps: the overflow and underflow guards above prevent it.

Decomposition:
- Shared fp package holds:
  - E_WIDTH/M_WIDTH defaults
  - packed-field index constants (sign bit, exp range, mant range)
  - FSM state enum
  - EXP_MAX constant (all ones)
- Optional sub-module fp_norm_shift_step: one-cycle combinational step computing next {exp, mant, done, unf}. Shared by CHECK/SHIFT.

Test Plan (E_WIDTH=8, M_WIDTH=23):
- Carry case: sum_in = {0, 8'h80, 24'hC00000} → result {0, 8'h81, 23'h600000}; valid_out 2 cycles after accept; no flags.
- Left-normalize: {1, 8'h80, 24'h100000} → 2 shifts → {1, 8'h7E, 23'h400000}; valid_out 4 cycles after accept.
- Zero and overflow:
  - {1, 8'h55, 24'h0} → result 0, zero_flag = 1.
  - {0, 8'hFE, 24'h800000} → {0, 8'hFF, 23'h0}, ovf_flag = 1.
- Underflow: {0, 8'h01, 24'h000001} → one shift → {0, 8'h00, 23'h000002}, unf_flag = 1; valid_out 3 cycles after accept.
- Special case with backpressure: s_case_in = 1, {0, 8'hFF, 24'h400001}, ready_out held low 3 cycles.
  - Result must be {0, 8'hFF, 23'h400001}, stable throughout.
  - ready_in stays 0 until the cycle after the ready_out handshake.
- Reset mid-SHIFT: start {0, 8'h80, 24'h000100}, assert rst during SHIFT → valid_out/result/flags = 0 immediately; ready_in = 1 after release; a fresh operation then completes correctly.
